fp_mul: RTL and testbench

Single-cycle-registered IEEE-754 binary floating-point multiplier supporting double (binary64) and single (binary32) precision, selected per operation by a format input. Sits in the FP datapath next to the adder/subtractor units and is exercised by file-driven regression benches comparing `out_result` against a golden model. Arithmetic is purely combinational; the result is captured in an output register.

---
 rtl/fp_mul.sv | 145 ++++++++++++++
 tb/tb_fp_mul.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fp_mul.sv
// fp_mul: IEEE-754 binary64/binary32 multiplier, round-to-nearest-even, flush-to-zero, registered output.
// Define FP_MUL_PIPE_EN to add a register between the significand multiply and normalize/round (latency 2).
module fp_mul (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic [63:0] in_numA,
    input  logic [63:0] in_numB,
    input  logic        in_fmt,
    output logic [63:0] out_result
);

    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_e;

    typedef struct packed {
        logic               fmt;
        logic               sign;
        special_e           special;
        logic signed [12:0] exp_sum;
        logic [105:0]       prod;
    } mul_stage_t;

    mul_stage_t mul_s;
    mul_stage_t rnd_s;

    logic        sign_a, sign_b;
    logic [10:0] exp_a, exp_b;
    logic [51:0] frac_a, frac_b;
    logic        max_a, max_b;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    // Single fractions are left-aligned in the 52-bit field so both formats share one multiplier.
    always_comb begin : decode
        if (in_fmt) begin
            sign_a = in_numA[63];
            sign_b = in_numB[63];
            exp_a  = in_numA[62:52];
            exp_b  = in_numB[62:52];
            frac_a = in_numA[51:0];
            frac_b = in_numB[51:0];
            max_a  = (in_numA[62:52] == 11'h7FF);
            max_b  = (in_numB[62:52] == 11'h7FF);
        end else begin
            sign_a = in_numA[31];
            sign_b = in_numB[31];
            exp_a  = {3'b000, in_numA[30:23]};
            exp_b  = {3'b000, in_numB[30:23]};
            frac_a = {in_numA[22:0], 29'b0};
            frac_b = {in_numB[22:0], 29'b0};
            max_a  = (in_numA[30:23] == 8'hFF);
            max_b  = (in_numB[30:23] == 8'hFF);
        end
    end

    assign nan_a  = max_a && (frac_a != '0);
    assign nan_b  = max_b && (frac_b != '0);
    assign inf_a  = max_a && (frac_a == '0);
    assign inf_b  = max_b && (frac_b == '0);
    assign zero_a = (exp_a == '0);
    assign zero_b = (exp_b == '0);

    always_comb begin : multiply
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        mul_s         = '0;
        mul_s.fmt     = in_fmt;
        mul_s.sign    = sign_a ^ sign_b;
        mul_s.exp_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b})
                        - (in_fmt ? 13'sd1023 : 13'sd127);
        mul_s.prod    = 106'({1'b1, frac_a}) * 106'({1'b1, frac_b});
        if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b))
            mul_s.special = SP_NAN;
        else if (inf_a || inf_b)
            mul_s.special = SP_INF;
        else if (zero_a || zero_b)
            mul_s.special = SP_ZERO;
        else
            mul_s.special = SP_NONE;
    end

`ifdef FP_MUL_PIPE_EN
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n)
            rnd_s <= '0;
        else
            rnd_s <= mul_s;
    end
`else
    assign rnd_s = mul_s;
`endif

    logic               norm_up;
    logic [104:0]       norm;
    logic               rnd_up_d, rnd_up_s, carry;
    logic [52:0]        frac_d_sum;
    logic [23:0]        frac_s_sum;
    logic signed [12:0] exp_fin;
    logic [63:0]        inf_res, zero_res, nan_res, norm_res;
    logic [63:0]        result_d;

    // norm holds the fraction bits below the (implicit) leading one of the normalized product.
    always_comb begin : normalize_round
        norm_up    = rnd_s.prod[105];
        norm       = norm_up ? rnd_s.prod[104:0] : {rnd_s.prod[103:0], 1'b0};
        rnd_up_d   = norm[52] & (norm[51] | (|norm[50:0]) | norm[53]);
        rnd_up_s   = norm[81] & (norm[80] | (|norm[79:0]) | norm[82]);
        frac_d_sum = {1'b0, norm[104:53]} + 53'(rnd_up_d);
        frac_s_sum = {1'b0, norm[104:82]} + 24'(rnd_up_s);
        carry      = rnd_s.fmt ? frac_d_sum[52] : frac_s_sum[23];
        exp_fin    = rnd_s.exp_sum + 13'(norm_up) + 13'(carry);

        if (rnd_s.fmt) begin
            nan_res  = 64'h7FF8_0000_0000_0000;
            inf_res  = {rnd_s.sign, 11'h7FF, 52'b0};
            zero_res = {rnd_s.sign, 63'b0};
            norm_res = {rnd_s.sign, exp_fin[10:0], frac_d_sum[51:0]};
        end else begin
            nan_res  = 64'h0000_0000_7FC0_0000;
            inf_res  = {32'b0, rnd_s.sign, 8'hFF, 23'b0};
            zero_res = {32'b0, rnd_s.sign, 31'b0};
            norm_res = {32'b0, rnd_s.sign, exp_fin[7:0], frac_s_sum[22:0]};
        end

        case (rnd_s.special)
            SP_NAN:  result_d = nan_res;
            SP_INF:  result_d = inf_res;
            SP_ZERO: result_d = zero_res;
            default: begin
                if (exp_fin >= (rnd_s.fmt ? 13'sd2047 : 13'sd255))
                    result_d = inf_res;
                else if (exp_fin <= 13'sd0)
                    result_d = zero_res;
                else
                    result_d = norm_res;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n)
            out_result <= '0;
        else
            out_result <= result_d;
    end

endmodule

// File: tb/tb_fp_mul.sv
// Self-checking bench for fp_mul: scoreboard of expected products, host-real model for random doubles.
module tb_fp_mul;

    logic        in_clk   = 1'b0;
    logic        in_rst_n = 1'b0;
    logic [63:0] in_numA  = 64'h0;
    logic [63:0] in_numB  = 64'h0;
    logic        in_fmt   = 1'b0;
    logic [63:0] out_result;

`ifdef FP_MUL_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [63:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   vectors_applied = 0;
    int   miscompares     = 0;

    fp_mul dut (
        .in_clk    (in_clk),
        .in_rst_n  (in_rst_n),
        .in_numA   (in_numA),
        .in_numB   (in_numB),
        .in_fmt    (in_fmt),
        .out_result(out_result)
    );

    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // On each falling edge: retire the oldest expectation once it has matured, then drive the next operation.
    task automatic apply(input logic [63:0] a, input logic [63:0] b, input logic fmt,
                         input logic [63:0] exp, input string tag);
        exp_t e;
        @(negedge in_clk);
        if (sb.size() == LAT) begin
            e = sb.pop_front();
            check(e.tag, out_result, e.exp);
        end
        in_numA = a;
        in_numB = b;
        in_fmt  = fmt;
        e.exp   = exp;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    logic [63:0] ra, rb, rp;

    initial begin
        in_numA = 64'h4000_0000_0000_0000;
        in_numB = 64'h4008_0000_0000_0000;
        in_fmt  = 1'b1;
        #12;
        check("reset_state", out_result, 64'h0);
        @(negedge in_clk);
        in_rst_n = 1'b1;
        repeat (LAT) @(negedge in_clk);
        check("first_after_reset", out_result, 64'h4018_0000_0000_0000);

        apply(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 1'b1, 64'h4018_0000_0000_0000, "d_2x3");
        apply(64'hBFF8_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1, 64'hC008_0000_0000_0000, "d_sign");
        apply(64'h0000_0000_4000_0000, 64'h0000_0000_4040_0000, 1'b0, 64'h0000_0000_40C0_0000, "s_2x3");
        apply(64'hFFFF_FFFF_4000_0000, 64'h1234_5678_4040_0000, 1'b0, 64'h0000_0000_40C0_0000, "s_upper_ignored");
        apply(64'h3FF0_0000_0000_0001, 64'h3FF0_0000_0000_0001, 1'b1, 64'h3FF0_0000_0000_0002, "d_rne");
        apply(64'h7FEF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000, 1'b1, 64'h7FF0_0000_0000_0000, "d_overflow");
        apply(64'h7FF0_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1, 64'h7FF8_0000_0000_0000, "d_inf_x_zero");
        apply(64'hFFF0_0000_0000_0001, 64'h3FF0_0000_0000_0000, 1'b1, 64'h7FF8_0000_0000_0000, "d_nan");
        apply(64'h8000_0000_0000_0000, 64'h4014_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, "d_negzero");
        apply(64'h0010_0000_0000_0000, 64'h3FE0_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000, "d_underflow");
        apply(64'h8000_0000_0000_0001, 64'h4000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, "d_subnormal");
        apply(64'h7FF0_0000_0000_0000, 64'hC000_0000_0000_0000, 1'b1, 64'hFFF0_0000_0000_0000, "d_neg_inf");
        apply(64'h0000_0000_3F80_0001, 64'h0000_0000_3FC0_0000, 1'b0, 64'h0000_0000_3FC0_0002, "s_tie_up");
        apply(64'h0000_0000_3F80_0003, 64'h0000_0000_3FC0_0000, 1'b0, 64'h0000_0000_3FC0_0004, "s_tie_even");
        apply(64'h0000_0000_7F00_0000, 64'h0000_0000_4000_0000, 1'b0, 64'h0000_0000_7F80_0000, "s_overflow");
        apply(64'h0000_0000_7F80_0000, 64'h0000_0000_0000_0000, 1'b0, 64'h0000_0000_7FC0_0000, "s_inf_x_zero");
        apply(64'h0000_0000_FFC0_0001, 64'h0000_0000_3F80_0000, 1'b0, 64'h0000_0000_7FC0_0000, "s_nan");
        apply(64'h0000_0000_7F80_0000, 64'h0000_0000_C000_0000, 1'b0, 64'h0000_0000_FF80_0000, "s_neg_inf");
        apply(64'h0000_0000_BF80_0000, 64'h0000_0000_4040_0000, 1'b0, 64'h0000_0000_C040_0000, "s_neg");
        apply(64'h0000_0000_3FFF_FFFF, 64'h0000_0000_3FFF_FFFF, 1'b0, 64'h0000_0000_407F_FFFE, "s_max_mant");

        // Mid-stream asynchronous reset discards the in-flight result.
        apply(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 1'b1, 64'h4018_0000_0000_0000, "d_pre_reset");
        @(posedge in_clk);
        #2 in_rst_n = 1'b0;
        #1 check("async_reset", out_result, 64'h0);
        sb.delete();
        @(negedge in_clk);
        in_rst_n = 1'b1;
        repeat (LAT) @(negedge in_clk);
        check("reset_release", out_result, 64'h4018_0000_0000_0000);

        // Random normal doubles against the host's round-to-nearest-even multiply, interleaved with singles.
        for (int i = 0; i < 24; i++) begin
            ra = {1'($urandom_range(0, 1)), 11'($urandom_range(700, 1300)), 20'($urandom), 32'($urandom)};
            rb = {1'($urandom_range(0, 1)), 11'($urandom_range(700, 1300)), 20'($urandom), 32'($urandom)};
            rp = $realtobits($bitstoreal(ra) * $bitstoreal(rb));
            apply(ra, rb, 1'b1, rp, $sformatf("d_rand%0d", i));
            apply(64'hDEAD_BEEF_3FC0_0000, 64'h0000_0000_3FC0_0000, 1'b0, 64'h0000_0000_4010_0000, "s_alt");
        end

        repeat (LAT) apply(64'h0, 64'h0, 1'b1, 64'h0, "drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
